// File: rtl/mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// mul_seq_ctrl : T-state strobe sequencer for the aluNacc datapath.
// Optional single-step mode with MULSEQ_STEP_EN.  Rev 1.0
// ============================================================================
module mul_seq_ctrl #(
  parameter int N_BITS = 4,
  parameter int CW     = 4
) (
  input  logic       clk,
  input  logic       clr_n,
`ifdef MULSEQ_STEP_EN
  input  logic       step,
`endif
  input  logic       start,
  input  logic [1:0] op,
  output logic       busy,
  output logic       done,
  output logic       clr,
  output logic       ah_reset,
  output logic       ah_inen,
  output logic [1:0] hs,
  output logic [1:0] ls,
  output logic       s_add,
  output logic       s_sub,
  output logic       s_and,
  output logic       s_mul,
  output logic       acc_oen
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLEAR  = 4'd1;
  localparam logic [3:0] S_LOAD_H = 4'd2;
  localparam logic [3:0] S_XFER_L = 4'd3;
  localparam logic [3:0] S_CLR_H  = 4'd4;
  localparam logic [3:0] S_ADD    = 4'd5;
  localparam logic [3:0] S_SHIFT  = 4'd6;
  localparam logic [3:0] S_EXEC   = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_MUL = 2'b11;

  localparam logic [1:0] HL_HOLD  = 2'b00;
  localparam logic [1:0] HL_SHR   = 2'b01;
  localparam logic [1:0] HL_LOAD  = 2'b11;

  localparam logic [CW-1:0] LAST_ITER = CW'(N_BITS - 1);

  logic [3:0]    state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [1:0]    op_q, op_nx;
  logic          advance;

`ifdef MULSEQ_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  // IDLE ignores advance so a start request is accepted on any clock.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    case (state)
      S_IDLE:   if (start) begin
                  op_nx    = op;
                  state_nx = S_CLEAR;
                end
      S_CLEAR:  if (advance) state_nx = S_LOAD_H;
      S_LOAD_H: if (advance) state_nx = (op_q == OP_MUL) ? S_XFER_L : S_EXEC;
      S_XFER_L: if (advance) state_nx = S_CLR_H;
      S_CLR_H:  begin
                  cnt_nx = '0;
                  if (advance) state_nx = S_ADD;
                end
      S_ADD:    if (advance) state_nx = S_SHIFT;
      S_SHIFT:  if (advance) begin
                  cnt_nx   = cnt + CW'(1);
                  state_nx = (cnt == LAST_ITER) ? S_DONE : S_ADD;
                end
      S_EXEC:   if (advance) state_nx = S_DONE;
      S_DONE:   if (advance) state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  // Outputs are decoded from the state being entered, then registered.
  logic       d_busy, d_done, d_clr, d_ah_reset, d_ah_inen, d_acc_oen;
  logic [1:0] d_hs, d_ls;
  logic       d_s_add, d_s_sub, d_s_and, d_s_mul;

  always_comb begin
    d_busy     = (state_nx != S_IDLE);
    d_done     = 1'b0;
    d_clr      = 1'b0;
    d_ah_reset = 1'b0;
    d_ah_inen  = 1'b0;
    d_acc_oen  = 1'b0;
    d_hs       = HL_HOLD;
    d_ls       = HL_HOLD;
    d_s_add    = 1'b0;
    d_s_sub    = 1'b0;
    d_s_and    = 1'b0;
    d_s_mul    = 1'b0;
    case (state_nx)
      S_CLEAR:  d_clr = 1'b1;
      S_LOAD_H: begin
                  d_ah_inen = 1'b1;
                  d_hs      = HL_LOAD;
                end
      S_XFER_L: d_ls = HL_LOAD;
      S_CLR_H:  d_ah_reset = 1'b1;
      S_ADD:    begin
                  d_hs    = HL_LOAD;
                  d_s_mul = 1'b1;
                end
      S_SHIFT:  begin
                  d_hs = HL_SHR;
                  d_ls = HL_SHR;
                end
      S_EXEC:   begin
                  d_hs    = HL_LOAD;
                  d_s_add = (op_nx == OP_ADD);
                  d_s_sub = (op_nx == OP_SUB);
                  d_s_and = (op_nx == OP_AND);
                end
      S_DONE:   begin
                  d_done    = 1'b1;
                  d_acc_oen = 1'b1;
                end
      default:  ;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      op_q     <= 2'b00;
      busy     <= 1'b0;
      done     <= 1'b0;
      clr      <= 1'b0;
      ah_reset <= 1'b0;
      ah_inen  <= 1'b0;
      hs       <= HL_HOLD;
      ls       <= HL_HOLD;
      s_add    <= 1'b0;
      s_sub    <= 1'b0;
      s_and    <= 1'b0;
      s_mul    <= 1'b0;
      acc_oen  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      op_q     <= op_nx;
      busy     <= d_busy;
      done     <= d_done;
      clr      <= d_clr;
      ah_reset <= d_ah_reset;
      ah_inen  <= d_ah_inen;
      hs       <= d_hs;
      ls       <= d_ls;
      s_add    <= d_s_add;
      s_sub    <= d_s_sub;
      s_and    <= d_s_and;
      s_mul    <= d_s_mul;
      acc_oen  <= d_acc_oen;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// tb_mul_seq_ctrl : directed bench with a per-op strobe-trace model.  Rev 1.0
// ============================================================================
module tb_mul_seq_ctrl;
  localparam int N_BITS = 4;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic       step = 1'b1;
  logic       start = 1'b0;
  logic [1:0] op_in = 2'b00;
  logic       busy, done, clr, ah_reset, ah_inen, acc_oen;
  logic [1:0] hs, ls;
  logic       s_add, s_sub, s_and, s_mul;

  int checks = 0;
  int errors = 0;
  bit run = 1'b0;

  always #5 clk = ~clk;

  mul_seq_ctrl #(.N_BITS(N_BITS), .CW(4)) dut (
    .clk(clk), .clr_n(clr_n),
`ifdef MULSEQ_STEP_EN
    .step(step),
`endif
    .start(start), .op(op_in), .busy(busy), .done(done), .clr(clr),
    .ah_reset(ah_reset), .ah_inen(ah_inen), .hs(hs), .ls(ls),
    .s_add(s_add), .s_sub(s_sub), .s_and(s_and), .s_mul(s_mul),
    .acc_oen(acc_oen)
  );

  // Vector layout: busy done clr ah_reset ah_inen hs[2] ls[2] sel[4] acc_oen
  function automatic logic [13:0] mk(logic b, logic d, logic c, logic ar, logic ai,
                                     logic [1:0] h, logic [1:0] l, logic [3:0] sel,
                                     logic oe);
    return {b, d, c, ar, ai, h, l, sel, oe};
  endfunction

  logic [13:0] actual;
  assign actual = {busy, done, clr, ah_reset, ah_inen, hs, ls, s_add, s_sub, s_and, s_mul, acc_oen};

  // Model: on acceptance, queue the whole per-cycle strobe trace of that op.
  logic [13:0] q[$];
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) q.delete();
    else if (q.size() > 0) void'(q.pop_front());
    else if (start) begin
      q.push_back(mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 0));
      q.push_back(mk(1, 0, 0, 0, 1, 2'b11, 2'b00, 4'b0000, 0));
      if (op_in == 2'b11) begin
        q.push_back(mk(1, 0, 0, 0, 0, 2'b00, 2'b11, 4'b0000, 0));
        q.push_back(mk(1, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 0));
        for (int k = 0; k < N_BITS; k++) begin
          q.push_back(mk(1, 0, 0, 0, 0, 2'b11, 2'b00, 4'b0001, 0));
          q.push_back(mk(1, 0, 0, 0, 0, 2'b01, 2'b01, 4'b0000, 0));
        end
      end else begin
        q.push_back(mk(1, 0, 0, 0, 0, 2'b11, 2'b00, 4'b1000 >> op_in, 0));
      end
      q.push_back(mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 1));
    end
  end

  logic [13:0] expected;
  always_comb expected = (q.size() > 0) ? q[0] : 14'd0;

  always @(negedge clk) begin
    if (run) begin
      checks++;
      if (actual !== expected) begin
        errors++;
        $display("FAIL trace t=%0t got=%b want=%b", $time, actual, expected);
      end
      checks++;
      if (!$onehot0({s_add, s_sub, s_and, s_mul}) || !$onehot0({ah_inen, ah_reset, clr})) begin
        errors++;
        $display("FAIL exclusive t=%0t got sel=%b strobes=%b want onehot0",
                 $time, {s_add, s_sub, s_and, s_mul}, {ah_inen, ah_reset, clr});
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  logic [13:0] trace[0:40];
  int lat, ndone;

  // Launches one op; noise_at>1 re-pulses start with a different op mid-run.
  task automatic run_op(input logic [1:0] o, input int noise_at);
    @(negedge clk);
    start = 1'b1;
    op_in = o;
    lat   = 0;
    ndone = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      trace[i] = actual;
      if (i == 1) start = 1'b0;
      if (i == noise_at) begin start = 1'b1; op_in = 2'b01; end
      if (i == noise_at + 1) start = 1'b0;
      if (done) begin
        ndone++;
        if (lat == 0) lat = i;
      end
      if (lat != 0 && i >= lat + 3) break;
    end
    start = 1'b0;
  endtask

  int first_done, last_done, gap_bad, idle_cnt;

  initial begin
    #2 clr_n = 1'b0;
    run = 1'b1;
    #1 chk("reset_outputs", int'(actual), 0);
    repeat (3) @(negedge clk);
    clr_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_busy", int'(busy), 0);

    // MUL trace and latency
    run_op(2'b11, 0);
    chk("mul_latency", lat, 13);
    chk("mul_done_pulses", ndone, 1);
    chk("mul_t1_clr", int'(trace[1]), int'(mk(1, 0, 1, 0, 0, 2'b00, 2'b00, 4'b0000, 0)));
    chk("mul_t2_load", int'(trace[2]), int'(mk(1, 0, 0, 0, 1, 2'b11, 2'b00, 4'b0000, 0)));
    chk("mul_t3_xfer", int'(trace[3]), int'(mk(1, 0, 0, 0, 0, 2'b00, 2'b11, 4'b0000, 0)));
    chk("mul_t4_ahrst", int'(trace[4]), int'(mk(1, 0, 0, 1, 0, 2'b00, 2'b00, 4'b0000, 0)));
    chk("mul_t11_add", int'(trace[11]), int'(mk(1, 0, 0, 0, 0, 2'b11, 2'b00, 4'b0001, 0)));
    chk("mul_t12_shift", int'(trace[12]), int'(mk(1, 0, 0, 0, 0, 2'b01, 2'b01, 4'b0000, 0)));
    chk("mul_t13_done", int'(trace[13]), int'(mk(1, 1, 0, 0, 0, 2'b00, 2'b00, 4'b0000, 1)));
    chk("mul_t14_idle", int'(trace[14]), 0);

    // Single-cycle ops
    run_op(2'b00, 0);
    chk("add_latency", lat, 4);
    chk("add_exec_sel", int'({trace[3][4:1], trace[3][8:7]}), int'(6'b1000_11));
    run_op(2'b01, 0);
    chk("sub_latency", lat, 4);
    chk("sub_exec_sel", int'({trace[3][4:1], trace[3][8:7]}), int'(6'b0100_11));
    run_op(2'b10, 0);
    chk("and_latency", lat, 4);
    chk("and_exec_sel", int'({trace[3][4:1], trace[3][8:7]}), int'(6'b0010_11));

    // start and op disturbed during MUL iterations
    run_op(2'b11, 6);
    chk("noise_mul_latency", lat, 13);
    chk("noise_done_pulses", ndone, 1);
    chk("noise_t11_add", int'(trace[11]), int'(mk(1, 0, 0, 0, 0, 2'b11, 2'b00, 4'b0001, 0)));

    // start held high: one op every 5 cycles
    @(negedge clk);
    start = 1'b1;
    op_in = 2'b00;
    first_done = 0; last_done = 0; gap_bad = 0; ndone = 0; idle_cnt = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done) begin
        if (first_done == 0) first_done = i;
        else if (i - last_done != 5) gap_bad++;
        last_done = i;
        ndone++;
      end
      if (!busy) idle_cnt++;
    end
    start = 1'b0;
    chk("held_first_done", first_done, 4);
    chk("held_done_count", ndone, 4);
    chk("held_gap_errors", gap_bad, 0);
    chk("held_idle_cycles", idle_cnt, 4);
    repeat (6) @(negedge clk);

    // Asynchronous abort in the middle of MUL
    @(negedge clk);
    start = 1'b1;
    op_in = 2'b11;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre_state", int'({hs, s_mul}), int'(3'b11_1));
    #2 clr_n = 1'b0;
    #1 chk("abort_outputs", int'(actual), 0);
    @(negedge clk);
    clr_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle_busy", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
